// File: rtl/ladybird_config.sv
// Shared ladybird configuration: datapath width, LFSR taps and bus response stage type.
package ladybird_config;

  localparam int unsigned XLEN = 32;

  // x^16 + x^14 + x^13 + x^11 + 1; bit k-1 set for each term x^k.
  localparam logic [15:0] LADYBIRD_LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } bus_rsp_t;

endpackage

// File: rtl/ladybird_lfsr.sv
// Fibonacci LFSR shifting right; the feedback bit enters at the MSB.
// Ports:
//   clk    - clock, rising edge
//   anrst  - asynchronous reset, active-low (loads SEED)
//   nrst   - synchronous reset, active-low (loads SEED)
//   en_i   - advance one step this cycle
//   q_o    - current LFSR state
module ladybird_lfsr #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             anrst,
  input  logic             nrst,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             fb;

  // TAPS bit k-1 marks polynomial term x^k; in a right-shifting register that
  // term is read from state bit WIDTH-k.
  always_comb begin
    fb = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (TAPS[i]) fb = fb ^ q_q[WIDTH-1-i];
    end
    q_d = q_q;
    if (en_i) q_d = {fb, q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst)     q_q <= SEED;
    else if (!nrst) q_q <= SEED;
    else            q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/ladybird_bus_sram.sv
// Responder end of the ladybird req/gnt/data_gnt bus backed by a word-organised SRAM.
// One transaction accepted per cycle; one in-order data_gnt per accept after READ_LATENCY cycles.
// Ports:
//   clk, anrst (async, active-low), nrst (sync, active-low)
//   req_i, addr_i (byte address), wstrb_i (all-zero = read), wdata_i
//   gnt_o (combinational accept), data_gnt_o, rdata_o (zero unless data_gnt_o)
module ladybird_bus_sram
  import ladybird_config::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [15:0] STALL_SEED   = 16'hACE1,
  parameter              MEM_INIT     = ""
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              nrst,
  input  logic              req_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN/8-1:0] wstrb_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              gnt_o,
  output logic              data_gnt_o,
  output logic [XLEN-1:0]   rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = XLEN / 8;

  logic [15:0]     lfsr;
  logic            stall;
  logic            accept;
  logic            is_write;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] mem_q [DEPTH];
  bus_rsp_t        rsp_q [READ_LATENCY];
  bus_rsp_t        rsp0_d;

  // Upper address bits are ignored so accesses wrap modulo DEPTH words.
  logic unused_bits;
  assign unused_bits = ^{addr_i[XLEN-1:2+AW], addr_i[1:0], lfsr[15:1]};

  ladybird_lfsr #(
    .WIDTH (16),
    .TAPS  (LADYBIRD_LFSR_TAPS),
    .SEED  (STALL_SEED)
  ) u_lfsr (
    .clk   (clk),
    .anrst (anrst),
    .nrst  (nrst),
    .en_i  (1'b1),
    .q_o   (lfsr)
  );

  assign stall    = STALL_EN & lfsr[0];
  assign gnt_o    = req_i & ~stall & nrst;
  assign accept   = req_i & gnt_o;
  assign is_write = |wstrb_i;
  assign idx      = addr_i[2 +: AW];

  // SRAM is never reset; a write granted before a reset stays committed.
  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wstrb_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Stage 0 samples the word synchronously; writes respond with zero data.
  always_comb begin
    rsp0_d       = '0;
    rsp0_d.valid = accept;
    if (accept && !is_write) rsp0_d.data = mem_q[idx];
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) rsp_q[i] <= '0;
    end else if (!nrst) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) rsp_q[i] <= '0;
    end else begin
      rsp_q[0] <= rsp0_d;
      for (int unsigned i = 1; i < READ_LATENCY; i++) rsp_q[i] <= rsp_q[i-1];
    end
  end

  assign data_gnt_o = rsp_q[READ_LATENCY-1].valid;
  assign rdata_o    = rsp_q[READ_LATENCY-1].valid ? rsp_q[READ_LATENCY-1].data : '0;

`ifndef SYNTHESIS
  // Primary must hold the request payload while waiting for gnt.
  a_req_stable : assert property (@(posedge clk) disable iff (!anrst)
    (req_i && nrst && !gnt_o) |=> ($stable(addr_i) && $stable(wstrb_i) && $stable(wdata_i)));

  a_req_known : assert property (@(posedge clk) disable iff (!anrst) !$isunknown(req_i));
`endif

endmodule

// File: tb/tb_ladybird_bus_sram.sv
module tb_ladybird_bus_sram;

  logic        clk = 1'b0;
  logic        anrst, nrst;
  logic        req;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        gnt1, dg1, gnt3, dg3;
  logic [31:0] rd1, rd3;
  logic        req_s, gnt_s, dg_s;
  logic [31:0] addr_s, wdata_s, rd_s;
  logic [3:0]  wstrb_s;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] mmem [1024];
  logic [31:0] exp1 [int];
  logic [31:0] exp3 [int];
  logic [15:0] ref_lfsr;

  always #5 clk = ~clk;

  ladybird_bus_sram #(.DEPTH(1024), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .anrst(anrst), .nrst(nrst), .req_i(req), .addr_i(addr), .wstrb_i(wstrb),
    .wdata_i(wdata), .gnt_o(gnt1), .data_gnt_o(dg1), .rdata_o(rd1));

  ladybird_bus_sram #(.DEPTH(1024), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .anrst(anrst), .nrst(nrst), .req_i(req), .addr_i(addr), .wstrb_i(wstrb),
    .wdata_i(wdata), .gnt_o(gnt3), .data_gnt_o(dg3), .rdata_o(rd3));

  ladybird_bus_sram #(.DEPTH(1024), .READ_LATENCY(1), .STALL_EN(1'b1)) u_st (
    .clk(clk), .anrst(anrst), .nrst(1'b1), .req_i(req_s), .addr_i(addr_s), .wstrb_i(wstrb_s),
    .wdata_i(wdata_s), .gnt_o(gnt_s), .data_gnt_o(dg_s), .rdata_o(rd_s));

  // Reference LFSR written from the polynomial directly: new bit = s0^s2^s3^s5.
  always @(posedge clk or negedge anrst) begin
    if (!anrst) ref_lfsr <= 16'hACE1;
    else ref_lfsr <= {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_rsp(input string tag, input logic dg, input logic [31:0] rd,
                         input logic ev, input logic [31:0] ed);
    chk({tag, "_data_gnt"}, {31'b0, dg}, {31'b0, ev});
    chk({tag, "_rdata"}, rd, ev ? ed : 32'h0);
  endtask

  // One bus cycle on the shared l1/l3 port, checked against the word-array model.
  task automatic step(input logic r, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d);
    logic [9:0]  idx;
    logic [31:0] rdv;
    req = r; addr = a; wstrb = s; wdata = d;
    @(negedge clk);
    chk("gnt_l1", {31'b0, gnt1}, {31'b0, r & nrst});
    chk("gnt_l3", {31'b0, gnt3}, {31'b0, r & nrst});
    chk_rsp("l1", dg1, rd1, exp1.exists(cyc), exp1.exists(cyc) ? exp1[cyc] : 32'h0);
    chk_rsp("l3", dg3, rd3, exp3.exists(cyc), exp3.exists(cyc) ? exp3[cyc] : 32'h0);
    if (r && nrst) begin
      idx = a[11:2];
      rdv = 32'h0;
      if (s == 4'h0) rdv = mmem[idx];
      for (int b = 0; b < 4; b++) if (s[b]) mmem[idx][8*b +: 8] = d[8*b +: 8];
      exp1[cyc+1] = rdv;
      exp3[cyc+3] = rdv;
    end
    if (!nrst) begin
      for (int k = cyc + 1; k <= cyc + 3; k++) begin
        if (exp1.exists(k)) exp1.delete(k);
        if (exp3.exists(k)) exp3.delete(k);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    logic [31:0] a, d, saved;
    logic [3:0]  s;
    int exp_gnt, got_gnt, got_dg;

    anrst = 1'b0; nrst = 1'b1;
    req = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    req_s = 1'b0; addr_s = 32'h80; wstrb_s = 4'hF; wdata_s = 32'hCAFEF00D;
    #3;
    chk_rsp("rst_l1", dg1, rd1, 1'b0, 32'h0);
    chk_rsp("rst_l3", dg3, rd3, 1'b0, 32'h0);
    chk("rst_gnt", {31'b0, gnt1}, 32'h0);
    repeat (2) @(posedge clk);
    #1 anrst = 1'b1;
    @(posedge clk); #1;

    // Fill a 64-word region so every later read has a known value.
    for (int i = 0; i < 64; i++) step(1'b1, i * 4, 4'hF, $urandom);

    step(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    chk("wr_rsp_dg", {31'b0, dg1}, 32'h1);
    chk("wr_rsp_zero", rd1, 32'h0);
    step(1'b1, 32'h10, 4'h0, 32'h0);
    chk("deadbeef", rd1, 32'hDEADBEEF);

    step(1'b1, 32'h20, 4'hF, 32'h11223344);
    step(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    step(1'b1, 32'h20, 4'h0, 32'h0);
    chk("byte_merge", rd1, 32'h11BB33DD);

    step(1'b1, 32'h0, 4'hF, 32'd1);
    step(1'b1, 32'h4, 4'hF, 32'd2);
    step(1'b1, 32'h8, 4'hF, 32'd3);
    step(1'b1, 32'h0, 4'h0, 32'h0);
    step(1'b1, 32'h4, 4'h0, 32'h0);
    step(1'b1, 32'h8, 4'h0, 32'h0);
    chk("lat3_rd1", rd3, 32'd1);
    step(1'b0, 32'h0, 4'h0, 32'h0);
    chk("lat3_rd2", rd3, 32'd2);
    step(1'b0, 32'h0, 4'h0, 32'h0);
    chk("lat3_rd3", rd3, 32'd3);

    step(1'b1, 32'h1000, 4'hF, 32'h5A5A5A5A);
    step(1'b1, 32'h0, 4'h0, 32'h0);
    chk("wrap", rd1, 32'h5A5A5A5A);

    // Randomized traffic within the filled region, with random ignored address bits.
    for (int i = 0; i < 300; i++) begin
      a = {$urandom_range(0, 1048575), 4'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 3) != 0, a, s, $urandom);
    end

    // Sync reset with a read in flight on the latency-3 port.
    step(1'b1, 32'h40, 4'hF, 32'h0BADF00D);
    step(1'b1, 32'h40, 4'h0, 32'h0);
    nrst = 1'b0;
    step(1'b1, 32'h40, 4'h0, 32'h0);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_drop_l3", {31'b0, dg3}, 32'h0);
      step(1'b0, 32'h0, 4'h0, 32'h0);
    end
    saved = mmem[16];
    step(1'b1, 32'h40, 4'h0, 32'h0);
    chk("post_rst_rd", rd1, saved);
    chk("post_rst_val", rd1, 32'h0BADF00D);
    repeat (4) step(1'b0, 32'h0, 4'h0, 32'h0);

    // Stalled port: req held 200 cycles, grants must follow the LFSR zero bits.
    exp_gnt = 0; got_gnt = 0; got_dg = 0;
    req_s = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("stall_gnt", {31'b0, gnt_s}, {31'b0, ~ref_lfsr[0]});
      if (!ref_lfsr[0]) exp_gnt++;
      if (gnt_s) got_gnt++;
      if (dg_s) begin
        got_dg++;
        chk("stall_rdata", rd_s, 32'h0);
      end
      @(posedge clk); #1;
    end
    req_s = 1'b0;
    @(negedge clk);
    if (dg_s) got_dg++;
    chk("stall_gnt_cnt", got_gnt, exp_gnt);
    chk("stall_dg_cnt", got_dg, got_gnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
